// File: rtl/modulation_gen_multistate.sv
// N-state square-wave modulation generator with double-buffered config and per-state step trigger.
// Optional output slew limiting is enabled by defining MODGEN_SLEW_EN.
`timescale 1ns/1ps
module modulation_gen_multistate #(
    parameter int OUTPUT_BIT = 14,
    parameter int NSTATE     = 4,
    parameter int CNT_BIT    = 32,
    parameter int SLEW_STEP  = 256,
    localparam int SW        = $clog2(NSTATE)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [CNT_BIT-1:0]             i_freq_cnt,
    input  logic [NSTATE*OUTPUT_BIT-1:0]   i_amp,
    input  logic [SW:0]                    i_state_num,
    input  logic [CNT_BIT-1:0]             i_trig_delay,
    input  logic                           i_cfg_load,
    output logic signed [OUTPUT_BIT-1:0]   o_mod_out,
    output logic [SW-1:0]                  o_state,
    output logic                           o_status,
    output logic                           o_stepTrig,
    output logic                           o_period_start,
    output logic                           o_cfg_ack
);

    if (NSTATE < 2 || NSTATE > 8 || SLEW_STEP < 1) begin : g_bad_param
        $error("modulation_gen_multistate: NSTATE must be 2..8 and SLEW_STEP >= 1");
    end

    localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);
    localparam logic [CNT_BIT-1:0] FREQ_RST = CNT_BIT'(125);
    localparam logic [SW:0]        NUM_MIN  = (SW+1)'(2);
    localparam logic [SW:0]        NUM_MAX  = (SW+1)'(NSTATE);
    localparam logic [SW:0]        NUM_ONE  = (SW+1)'(1);
    localparam logic [SW-1:0]      ST_ONE   = SW'(1);

    // Shadow (applied) configuration
    logic [CNT_BIT-1:0]           freq_sh;
    logic [CNT_BIT-1:0]           delay_sh;
    logic [NSTATE*OUTPUT_BIT-1:0] amp_sh;
    logic [SW:0]                  num_sh;

    logic [CNT_BIT-1:0]           elapsed;
    logic                         pending;
    logic                         running;

    logic [CNT_BIT-1:0]           in_freq;
    logic [SW:0]                  in_num;
    logic                         at_state_end;
    logic                         at_period_end;
    logic                         apply;
    logic [CNT_BIT-1:0]           eff_delay;
    logic [NSTATE*OUTPUT_BIT-1:0] eff_amp;
    logic [SW:0]                  eff_num;
    logic [SW-1:0]                nxt_state;
    logic [CNT_BIT-1:0]           nxt_elapsed;
    logic signed [OUTPUT_BIT-1:0] target;
    logic signed [OUTPUT_BIT-1:0] mod_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_freq = (i_freq_cnt == '0) ? CNT_ONE : i_freq_cnt;
        in_num  = i_state_num;
        if (i_state_num < NUM_MIN) begin
            in_num = NUM_MIN;
        end else if (i_state_num > NUM_MAX) begin
            in_num = NUM_MAX;
        end

        // A stopped generator or a period boundary is a safe point to swap config.
        at_state_end  = running && (elapsed == freq_sh - CNT_ONE);
        at_period_end = at_state_end && ({1'b0, o_state} == num_sh - NUM_ONE);
        apply         = (pending || i_cfg_load) && (!i_en || !running || at_period_end);

        eff_delay = apply ? i_trig_delay : delay_sh;
        eff_amp   = apply ? i_amp        : amp_sh;
        eff_num   = apply ? in_num       : num_sh;

        nxt_state   = '0;
        nxt_elapsed = '0;
        if (i_en && running) begin
            if (at_state_end) begin
                nxt_state = at_period_end ? '0 : o_state + ST_ONE;
            end else begin
                nxt_state   = o_state;
                nxt_elapsed = elapsed + CNT_ONE;
            end
        end

        target = '0;
        if (i_en) begin
            target = eff_amp[nxt_state*OUTPUT_BIT +: OUTPUT_BIT];
        end
    end

`ifdef MODGEN_SLEW_EN
    localparam logic signed [OUTPUT_BIT:0] SLEW_POS = (OUTPUT_BIT+1)'(SLEW_STEP);
    localparam logic signed [OUTPUT_BIT:0] SLEW_NEG = -SLEW_POS;

    logic signed [OUTPUT_BIT:0] slew_diff;

    // One extra bit keeps the signed distance from overflowing across full scale.
    always_comb begin
        slew_diff = {target[OUTPUT_BIT-1], target} - {o_mod_out[OUTPUT_BIT-1], o_mod_out};
        mod_nxt   = target;
        if (slew_diff > SLEW_POS) begin
            mod_nxt = o_mod_out + SLEW_POS[OUTPUT_BIT-1:0];
        end else if (slew_diff < SLEW_NEG) begin
            mod_nxt = o_mod_out - SLEW_POS[OUTPUT_BIT-1:0];
        end
    end
`else
    assign mod_nxt = target;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            freq_sh        <= FREQ_RST;
            delay_sh       <= '0;
            amp_sh         <= '0;
            num_sh         <= NUM_MIN;
            elapsed        <= '0;
            pending        <= 1'b0;
            running        <= 1'b0;
            o_state        <= '0;
            o_mod_out      <= '0;
            o_status       <= 1'b0;
            o_stepTrig     <= 1'b0;
            o_period_start <= 1'b0;
            o_cfg_ack      <= 1'b0;
        end else begin
            running <= i_en;
            pending <= apply ? 1'b0 : (pending || i_cfg_load);
            if (apply) begin
                freq_sh  <= in_freq;
                delay_sh <= i_trig_delay;
                amp_sh   <= i_amp;
                num_sh   <= in_num;
            end
            elapsed        <= nxt_elapsed;
            o_state        <= nxt_state;
            o_mod_out      <= mod_nxt;
            o_status       <= i_en && ({1'b0, nxt_state} >= (eff_num >> 1));
            o_stepTrig     <= i_en && (nxt_elapsed == eff_delay);
            o_period_start <= i_en && (nxt_state == '0) && (nxt_elapsed == '0);
            o_cfg_ack      <= apply;
        end
    end

endmodule

// File: tb/tb_modulation_gen_multistate.sv
// Directed self-checking bench for modulation_gen_multistate (default 14-bit, 4-state build).
`timescale 1ns/1ps
module tb_modulation_gen_multistate;

    localparam int OUTPUT_BIT = 14;
    localparam int NSTATE     = 4;
    localparam int CNT_BIT    = 32;
    localparam int SW         = 2;

`ifdef MODGEN_SLEW_EN
    localparam logic [19:0] MASK = 20'h0003F;
`else
    localparam logic [19:0] MASK = 20'hFFFFF;
`endif

    logic                          i_clk = 1'b0;
    logic                          i_rst_n = 1'b0;
    logic                          i_en = 1'b0;
    logic [CNT_BIT-1:0]            i_freq_cnt = '0;
    logic [NSTATE*OUTPUT_BIT-1:0]  i_amp = '0;
    logic [SW:0]                   i_state_num = '0;
    logic [CNT_BIT-1:0]            i_trig_delay = '0;
    logic                          i_cfg_load = 1'b0;
    logic signed [OUTPUT_BIT-1:0]  o_mod_out;
    logic [SW-1:0]                 o_state;
    logic                          o_status;
    logic                          o_stepTrig;
    logic                          o_period_start;
    logic                          o_cfg_ack;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected-value model state
    int m_freq;
    int m_num;
    int m_delay;
    int m_amp[4];

    logic [19:0] obs;
    assign obs = {o_mod_out, o_state, o_status, o_stepTrig, o_period_start, o_cfg_ack};

    modulation_gen_multistate #(
        .OUTPUT_BIT(OUTPUT_BIT),
        .NSTATE    (NSTATE),
        .CNT_BIT   (CNT_BIT),
        .SLEW_STEP (256)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_freq_cnt    (i_freq_cnt),
        .i_amp         (i_amp),
        .i_state_num   (i_state_num),
        .i_trig_delay  (i_trig_delay),
        .i_cfg_load    (i_cfg_load),
        .o_mod_out     (o_mod_out),
        .o_state       (o_state),
        .o_status      (o_status),
        .o_stepTrig    (o_stepTrig),
        .o_period_start(o_period_start),
        .o_cfg_ack     (o_cfg_ack)
    );

    always #5 i_clk = ~i_clk;

    // Expected {mod, state, status, trig, period_start, ack} for clock c of a run with state length f.
    function automatic logic [19:0] exp_word(input int c, input int f);
        int st;
        int el;
        st = (c / f) % m_num;
        el = c % f;
        exp_word = {14'(m_amp[st]), 2'(st), (st >= m_num / 2), (el == m_delay),
                    (st == 0 && el == 0), 1'b0};
    endfunction

    // Stop, load a config while disabled, then enable; returns at the edge where ack is visible.
    task automatic configure(input int f_in, input int n_in, input int dly,
                             input int a0, input int a1, input int a2, input int a3,
                             input int mf, input int mn);
        @(negedge i_clk);
        i_en         = 1'b0;
        i_freq_cnt   = f_in;
        i_state_num  = (SW+1)'(n_in);
        i_trig_delay = dly;
        i_amp        = {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
        i_cfg_load   = 1'b1;
        m_freq  = mf;
        m_num   = mn;
        m_delay = dly;
        m_amp   = '{a0, a1, a2, a3};
        @(negedge i_clk);
        i_cfg_load = 1'b0;
        i_en       = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        tests_run++;
        if (obs !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 20'h0);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (obs !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_idle got=%h exp=%h", obs, 20'h0);
        end
    endtask

`ifdef MODGEN_SLEW_EN
    task automatic test_slew();
        int slew_exp[5] = '{256, 512, 768, 1000, 1000};
        configure(8, 2, 0, 1000, 0, 0, 0, 8, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            tests_run++;
            if (o_mod_out !== 14'(slew_exp[c]) || (obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL slew c=%0d got=%0d/%h exp=%0d/%h", c, o_mod_out, obs & MASK,
                         slew_exp[c], exp_word(c, m_freq) & MASK);
            end
        end
    endtask
`endif

    task automatic test_two_state();
        configure(4, 2, 0, 100, -100, 0, 0, 4, 2);
        tests_run++;
        if (o_cfg_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_state_ack got=%b exp=1", o_cfg_ack);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL two_state c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
    endtask

    task automatic test_four_state();
        configure(3, 4, 2, 0, 100, 200, 300, 3, 4);
        for (int c = 0; c < 24; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL four_state c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
        i_en = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if ((obs & MASK) !== 20'h0) begin
            tests_failed++;
            $display("FAIL en_fall got=%h exp=%h", obs, 20'h0);
        end
    endtask

    task automatic test_retune();
        logic [19:0] e;
        configure(5, 4, 0, 10, 20, 30, 40, 5, 4);
        for (int c = 0; c < 36; c++) begin
            @(negedge i_clk);
            e = (c < 20) ? exp_word(c, 5) : (exp_word(c - 20, 2) | 20'(c == 20));
            tests_run++;
            if ((obs & MASK) !== (e & MASK)) begin
                tests_failed++;
                $display("FAIL retune c=%0d got=%h exp=%h", c, obs, e);
            end
            if (c == 6) begin
                i_cfg_load = 1'b1;
                i_freq_cnt = 3;
            end else if (c == 7) begin
                i_cfg_load = 1'b0;
                i_freq_cnt = 2;
            end
        end
    endtask

    task automatic test_no_trig();
        configure(7, 2, 7, 5, -5, 0, 0, 7, 2);
        for (int c = 0; c < 21; c++) begin
            @(negedge i_clk);
            tests_run++;
            if (o_stepTrig !== 1'b0 || (obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL no_trig c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
    endtask

    task automatic test_freq0_clamp();
        configure(0, 0, 0, 1, 2, 3, 4, 1, 2);
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL freq0_num0 c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
        configure(0, 7, 0, 1, 2, 3, 4, 1, 4);
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL freq0_num7 c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
    endtask

    task automatic test_async_reset();
        configure(4, 2, 0, 100, -100, 0, 0, 4, 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        #1;
        tests_run++;
        if (obs !== 20'h0) begin
            tests_failed++;
            $display("FAIL async_reset got=%h exp=%h", obs, 20'h0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (obs !== 20'h0) begin
            tests_failed++;
            $display("FAIL post_reset_idle got=%h exp=%h", obs, 20'h0);
        end
        i_en    = 1'b1;
        m_freq  = 125;
        m_num   = 2;
        m_delay = 0;
        m_amp   = '{0, 0, 0, 0};
        for (int c = 0; c < 130; c++) begin
            @(negedge i_clk);
            tests_run++;
            if ((obs & MASK) !== (exp_word(c, m_freq) & MASK)) begin
                tests_failed++;
                $display("FAIL default_cfg c=%0d got=%h exp=%h", c, obs, exp_word(c, m_freq));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef MODGEN_SLEW_EN
        test_slew();
`endif
        test_two_state();
        test_four_state();
        test_retune();
        test_no_trig();
        test_freq0_clamp();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
